// File: rtl/motion_ctrl_pkg.sv
// Shared definitions for the motion-control AXI4-Lite register block:
// response codes, write/read channel state enums and the address-width helper.
package motion_ctrl_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // Byte-address width: register index bits plus byte-lane offset bits.
    function automatic int addr_w(input int num_regs, input int data_width);
        return $clog2(num_regs) + $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/motion_ctrl_reg_bank.sv
// Register array with per-byte strobe writes and an asynchronous read mux.
// Read-only slots are never written; their read value comes from status_i.
module motion_ctrl_reg_bank
    import motion_ctrl_pkg::*;
#(
    parameter int                      DATA_WIDTH = 32,
    parameter int                      NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]     RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0]    wr_idx_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb_i,
    input  logic [$clog2(NUM_REGS)-1:0]    rd_idx_i,
    output logic [DATA_WIDTH-1:0]          rd_data_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // Strobe-masked update of RW registers; RO slots keep their reset value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else if (wr_en_i && !RO_MASK[wr_idx_i]) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_i[b]) regs_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
            end
        end
    end

    // Read mux: live hardware status for RO slots, stored contents otherwise.
    always_comb begin
        if (RO_MASK[rd_idx_i]) rd_data_o = status_i[rd_idx_i*DATA_WIDTH +: DATA_WIDTH];
        else                   rd_data_o = regs_q[rd_idx_i];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_flat_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: rtl/motion_ctrl_axil_regs.sv
// AXI4-Lite slave register file for the motion controller.
// Optional feature macro: MOTION_CTRL_REGS_ERR_RESP_EN (SLVERR on RO writes).
module motion_ctrl_axil_regs
    import motion_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                                    ACLK,
    input  logic                                    ARESET,
    input  logic [addr_w(NUM_REGS, DATA_WIDTH)-1:0] S_AXI_AWADDR,
    input  logic                                    S_AXI_AWVALID,
    output logic                                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                 S_AXI_WSTRB,
    input  logic                                    S_AXI_WVALID,
    output logic                                    S_AXI_WREADY,
    output logic [1:0]                              S_AXI_BRESP,
    output logic                                    S_AXI_BVALID,
    input  logic                                    S_AXI_BREADY,
    input  logic [addr_w(NUM_REGS, DATA_WIDTH)-1:0] S_AXI_ARADDR,
    input  logic                                    S_AXI_ARVALID,
    output logic                                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                   S_AXI_RDATA,
    output logic [1:0]                              S_AXI_RRESP,
    output logic                                    S_AXI_RVALID,
    input  logic                                    S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0]          reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS-1:0]                     wr_pulse
);

    localparam int ADDR_W = addr_w(NUM_REGS, DATA_WIDTH);
    localparam int LSB    = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, bank_rdata;
    logic                  aw_fire, w_fire, ar_fire, commit;
    logic [IDX_W-1:0]      cm_idx;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [STRB_W-1:0]     cm_strb;
    logic                  unused_addr_lsbs;

    // Byte-lane offset bits do not take part in register selection.
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

    // Handshake outputs are forced low while reset is held.
    assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_held_q && !ARESET;
    assign S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_held_q && !ARESET;
    assign S_AXI_BVALID  = (w_state_q == W_RESP) && !ARESET;
    assign S_AXI_BRESP   = ARESET ? 2'b00 : bresp_q;
    assign S_AXI_ARREADY = (r_state_q == R_IDLE) && !ARESET;
    assign S_AXI_RVALID  = (r_state_q == R_DATA) && !ARESET;
    assign S_AXI_RDATA   = ARESET ? '0 : rdata_q;
    // The address ports carry no bits above ADDR_W, so reads never error.
    assign S_AXI_RRESP   = OKAY;
    assign wr_pulse      = ARESET ? '0 : wr_pulse_q;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;

    // Write channel: latch AW/W independently, commit once both are present.
    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        commit     = 1'b0;
        cm_idx     = aw_held_q ? aw_idx_q : S_AXI_AWADDR[ADDR_W-1:LSB];
        cm_data    = w_held_q ? wdata_q : S_AXI_WDATA;
        cm_strb    = w_held_q ? wstrb_q : S_AXI_WSTRB;
        if (aw_fire) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[ADDR_W-1:LSB];
        end
        if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end
        case (w_state_q)
            W_IDLE: begin
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    commit             = 1'b1;
                    aw_held_d          = 1'b0;
                    w_held_d           = 1'b0;
                    w_state_d          = W_RESP;
                    wr_pulse_d[cm_idx] = !RO_MASK[cm_idx];
`ifdef MOTION_CTRL_REGS_ERR_RESP_EN
                    bresp_d            = RO_MASK[cm_idx] ? SLVERR : OKAY;
`else
                    bresp_d            = OKAY;
`endif
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                    bresp_d   = OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel: capture the addressed value on the AR handshake edge.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rdata_d   = bank_rdata;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Control state; reset abandons any half-collected write.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
            rdata_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rdata_q    <= rdata_d;
        end
    end

    // Captured write address/data; only meaningful while the held flags are set.
    always_ff @(posedge ACLK) begin
        aw_idx_q <= aw_idx_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

    motion_ctrl_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK),
        .RESET_VAL  (RESET_VAL)
    ) u_bank (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .wr_en_i    (commit),
        .wr_idx_i   (cm_idx),
        .wr_data_i  (cm_data),
        .wr_strb_i  (cm_strb),
        .rd_idx_i   (S_AXI_ARADDR[ADDR_W-1:LSB]),
        .rd_data_o  (bank_rdata),
        .status_i   (status_in),
        .reg_flat_o (reg_out)
    );

endmodule

// File: tb/tb_motion_ctrl_axil_regs.sv
// Self-checking bench for motion_ctrl_axil_regs with an array-based register model.
module tb_motion_ctrl_axil_regs;

    localparam int          DW = 32;
    localparam int          NR = 8;
    localparam logic [7:0]  RO = 8'h80;
    localparam logic [31:0] RV = 32'h5A5A_00F0;

    logic         ACLK = 0, ARESET = 1;
    logic [4:0]   S_AXI_AWADDR = 0, S_AXI_ARADDR = 0;
    logic         S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
    logic         S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0]  S_AXI_WDATA = 0;
    logic [3:0]   S_AXI_WSTRB = 0;
    logic         S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0]  S_AXI_RDATA;
    logic [255:0] reg_out, status_in = 0;
    logic [7:0]   wr_pulse;

    int passed = 0, total = 0;
    logic [31:0] model [NR];

    motion_ctrl_axil_regs #(.DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- reference model ----------------
    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        if (!RO[idx]) for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        return RO[idx] ? status_in[idx*32 +: 32] : model[idx];
    endfunction

    function automatic logic [1:0] model_bresp(input int idx);
`ifdef MOTION_CTRL_REGS_ERR_RESP_EN
        return RO[idx] ? 2'b10 : 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    // ---------------- bus drivers ----------------
    task automatic tick();
        @(posedge ACLK); #1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp,
                             output int pulses, output logic [7:0] pvec, output int aw_to_b, output bit tmo);
        bit aw_done = 0, w_done = 0, b_done = 0;
        int aw_cyc = -1, b_cyc = -1, cyc = 0;
        pulses = 0; pvec = 0; tmo = 0; resp = 2'b11;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_BREADY = 1;
        while (!b_done) begin
            S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            S_AXI_WVALID  = !w_done && cyc >= w_dly;
            @(negedge ACLK);
            pulses += $countones(wr_pulse);
            pvec |= wr_pulse;
            if (S_AXI_BVALID) begin resp = S_AXI_BRESP; b_done = 1; b_cyc = cyc; end
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin aw_done = 1; aw_cyc = cyc; end
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
            tick();
            cyc++;
            if (cyc > 60) begin tmo = 1; break; end
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        repeat (2) begin @(negedge ACLK); pulses += $countones(wr_pulse); pvec |= wr_pulse; end
        tick();
        aw_to_b = b_cyc - aw_cyc;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output bit tmo);
        bit hs = 0;
        int cyc = 0;
        tmo = 0; lat = -1; data = 'x; resp = 2'b11;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
        while (!hs) begin
            @(negedge ACLK); hs = S_AXI_ARREADY;
            tick();
            if (++cyc > 60) begin tmo = 1; break; end
        end
        S_AXI_ARVALID = 0;
        if (tmo) return;
        for (lat = 1; lat <= 60; lat++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) break;
            tick();
        end
        if (lat > 60) begin tmo = 1; return; end
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1; tick(); S_AXI_RREADY = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ARESET = 1;
        repeat (3) tick();
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000)
            $display("FAIL reset_ready got=%b exp=000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); else passed++;
        total++; if ({S_AXI_BVALID, S_AXI_RVALID, wr_pulse} !== 10'd0)
            $display("FAIL reset_valid got=%b exp=0", {S_AXI_BVALID, S_AXI_RVALID, wr_pulse}); else passed++;
        total++; if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'd0)
            $display("FAIL reset_data got=%h exp=0", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}); else passed++;
        ARESET = 0;
        tick();
        for (int i = 0; i < NR; i++) model[i] = RV;
        for (int i = 0; i < NR; i++) begin
            total++; if (reg_out[i*32 +: 32] !== RV)
                $display("FAIL reset_reg%0d got=%h exp=%h", i, reg_out[i*32 +: 32], RV); else passed++;
        end
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111)
            $display("FAIL idle_ready got=%b exp=111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); else passed++;
    endtask

    task automatic test_sequential();
        logic [1:0] resp; int pulses, a2b, lat; logic [7:0] pv; bit tmo; logic [31:0] rd;
        for (int i = 0; i < NR; i++) begin
            axi_write(5'(i*4), 32'(i+1), 4'hF, 0, 0, resp, pulses, pv, a2b, tmo);
            model_write(i, 32'(i+1), 4'hF);
            total++; if (tmo || resp !== model_bresp(i))
                $display("FAIL seq_bresp%0d got=%b tmo=%0d exp=%b", i, resp, tmo, model_bresp(i)); else passed++;
            total++; if (pv !== (RO[i] ? 8'h00 : 8'(1 << i)) || pulses != (RO[i] ? 0 : 1))
                $display("FAIL seq_pulse%0d got=%b count=%0d", i, pv, pulses); else passed++;
        end
        for (int i = 0; i < NR; i++) begin
            if (!RO[i]) begin
                total++; if (reg_out[i*32 +: 32] !== model[i])
                    $display("FAIL seq_regout%0d got=%h exp=%h", i, reg_out[i*32 +: 32], model[i]); else passed++;
            end
            axi_read(5'(i*4), rd, resp, lat, tmo);
            total++; if (tmo || rd !== model_read(i) || resp !== 2'b00 || lat != 1)
                $display("FAIL seq_read%0d got=%h resp=%b lat=%0d exp=%h", i, rd, resp, lat, model_read(i)); else passed++;
        end
    endtask

    task automatic test_strobes();
        logic [1:0] resp; int pulses, a2b, lat; logic [7:0] pv; bit tmo; logic [31:0] rd;
        axi_write(5'h00, 32'h0, 4'hF, 0, 0, resp, pulses, pv, a2b, tmo);
        axi_write(5'h00, 32'hAABBCCDD, 4'b0101, 0, 0, resp, pulses, pv, a2b, tmo);
        model[0] = 32'h00BB00DD;
        axi_read(5'h00, rd, resp, lat, tmo);
        total++; if (tmo || rd !== 32'h00BB00DD)
            $display("FAIL strobe_read got=%h exp=00bb00dd", rd); else passed++;
        axi_write(5'h00, 32'h11223344, 4'b0000, 0, 0, resp, pulses, pv, a2b, tmo);
        axi_read(5'h00, rd, resp, lat, tmo);
        total++; if (tmo || rd !== 32'h00BB00DD)
            $display("FAIL strobe_zero got=%h exp=00bb00dd", rd); else passed++;
    endtask

    task automatic test_ordering();
        logic [1:0] resp; int pulses, a2b, lat; logic [7:0] pv; bit tmo; logic [31:0] rd, d;
        d = $urandom;
        axi_write(5'h08, d, 4'hF, 3, 0, resp, pulses, pv, a2b, tmo);
        model_write(2, d, 4'hF);
        total++; if (tmo || pulses != 1 || pv !== 8'h04)
            $display("FAIL order_pulse got=%b count=%0d exp=00000100", pv, pulses); else passed++;
        total++; if (a2b != 1)
            $display("FAIL order_bvalid got=%0d cycles exp=1", a2b); else passed++;
        axi_read(5'h08, rd, resp, lat, tmo);
        total++; if (tmo || rd !== model_read(2))
            $display("FAIL order_read got=%h exp=%h", rd, model_read(2)); else passed++;
    endtask

    task automatic test_ro();
        logic [1:0] resp; int pulses, a2b, lat; logic [7:0] pv; bit tmo; logic [31:0] rd;
        status_in[7*32 +: 32] = 32'h12345678;
        axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, resp, pulses, pv, a2b, tmo);
        total++; if (tmo || resp !== model_bresp(7) || pulses != 0)
            $display("FAIL ro_write got=%b pulses=%0d exp=%b", resp, pulses, model_bresp(7)); else passed++;
        axi_read(5'h1C, rd, resp, lat, tmo);
        total++; if (tmo || rd !== 32'h12345678)
            $display("FAIL ro_read got=%h exp=12345678", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, old;
        bit ok;
        d = $urandom; old = model_read(3);
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 5'h0C;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
        @(negedge ACLK);
        ok = S_AXI_AWREADY && S_AXI_WREADY && S_AXI_ARREADY;
        tick();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        model_write(3, d, 4'hF);
        total++; if (!ok) $display("FAIL collide_ready got=0 exp=1"); else passed++;
        for (int c = 0; c < 5; c++) begin
            S_AXI_AWVALID = (c == 2); S_AXI_WVALID = (c == 2);
            @(negedge ACLK);
            total++; if (S_AXI_BVALID !== 1 || S_AXI_RVALID !== 1 || S_AXI_RDATA !== old
                         || S_AXI_AWREADY !== 0 || S_AXI_WREADY !== 0)
                $display("FAIL hold_c%0d bv=%b rv=%b rdata=%h awr=%b exp rdata=%h", c, S_AXI_BVALID,
                         S_AXI_RVALID, S_AXI_RDATA, S_AXI_AWREADY, old); else passed++;
            tick();
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        S_AXI_BREADY = 1; S_AXI_RREADY = 1; tick(); S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        total++; if (S_AXI_BVALID !== 0 || S_AXI_RVALID !== 0)
            $display("FAIL release bv=%b rv=%b exp=0", S_AXI_BVALID, S_AXI_RVALID); else passed++;
        total++; if (reg_out[3*32 +: 32] !== model[3])
            $display("FAIL collide_new got=%h exp=%h", reg_out[3*32 +: 32], model[3]); else passed++;
    endtask

    task automatic test_random();
        logic [1:0] resp; int pulses, a2b, lat, idx, awd, wd; logic [7:0] pv; bit tmo;
        logic [31:0] rd, d; logic [3:0] s;
        for (int n = 0; n < 40; n++) begin
            status_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            idx = $urandom_range(0, NR-1);
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; s = 4'($urandom); awd = $urandom_range(0, 3); wd = $urandom_range(0, 3);
                axi_write(5'(idx*4 + $urandom_range(0, 3)), d, s, awd, wd, resp, pulses, pv, a2b, tmo);
                model_write(idx, d, s);
                total++; if (tmo || resp !== model_bresp(idx) || pv !== (RO[idx] ? 8'h00 : 8'(1 << idx))
                             || pulses != (RO[idx] ? 0 : 1) || a2b != ((wd > awd) ? wd - awd : 0) + 1)
                    $display("FAIL rnd_wr%0d idx=%0d resp=%b pv=%b a2b=%0d", n, idx, resp, pv, a2b); else passed++;
            end else begin
                axi_read(5'(idx*4 + $urandom_range(0, 3)), rd, resp, lat, tmo);
                total++; if (tmo || rd !== model_read(idx) || resp !== 2'b00 || lat != 1)
                    $display("FAIL rnd_rd%0d idx=%0d got=%h exp=%h lat=%0d", n, idx, rd, model_read(idx), lat); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; int pulses, a2b, lat; logic [7:0] pv; bit tmo; logic [31:0] rd;
        bit ok;
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1; S_AXI_WVALID = 0;
        @(negedge ACLK); ok = S_AXI_AWREADY;
        tick(); S_AXI_AWVALID = 0;
        total++; if (!ok) $display("FAIL mid_aw got=0 exp=1"); else passed++;
        ARESET = 1; S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        @(negedge ACLK);
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                      wr_pulse, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== '0)
            $display("FAIL mid_outputs got nonzero exp=0"); else passed++;
        tick(); tick();
        S_AXI_WVALID = 0; ARESET = 0;
        tick();
        for (int i = 0; i < NR; i++) model[i] = RV;
        ok = 1;
        for (int i = 0; i < NR; i++) if (reg_out[i*32 +: 32] !== RV) ok = 0;
        total++; if (!ok) $display("FAIL mid_regs got=%h exp all %h", reg_out, RV); else passed++;
        axi_read(5'h04, rd, resp, lat, tmo);
        total++; if (tmo || rd !== RV) $display("FAIL mid_read got=%h exp=%h", rd, RV); else passed++;
        axi_write(5'h04, 32'h0BADF00D, 4'hF, 0, 0, resp, pulses, pv, a2b, tmo);
        model_write(1, 32'h0BADF00D, 4'hF);
        total++; if (tmo || pv !== 8'h02 || reg_out[32 +: 32] !== model[1])
            $display("FAIL mid_after got=%h pv=%b exp=%h", reg_out[32 +: 32], pv, model[1]); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_strobes();
        test_ordering();
        test_ro();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
